// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - control/add stage of a shift-add multiplier
// Sequences external A/Q shift registers through N add/shift rounds; {A,Q} holds the product at done.
module shift_add_mult_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] multiplier,
  input  logic [N-1:0] a_reg,
  input  logic         q_lsb,
  output logic [1:0]   a_ctrl,
  output logic [N-1:0] a_par,
  output logic         a_ser,
  output logic [1:0]   q_ctrl,
  output logic [N-1:0] q_par,
  output logic         q_ser,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    m_q, m_d;
  logic [N-1:0]    qr_q, qr_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N:0]      sum;

  // Carry-out is kept so the A MSB receives it on the following shift.
  assign sum = {1'b0, a_reg} + {1'b0, m_q};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    qr_d    = qr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          qr_d    = multiplier;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: state_d = ADD;
      ADD: begin
        carry_d = q_lsb ? sum[N] : 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        carry_d = 1'b0;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ADD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      qr_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      qr_q    <= qr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    a_ctrl = 2'b00;
    a_par  = '0;
    a_ser  = 1'b0;
    q_ctrl = 2'b00;
    q_par  = qr_q;
    q_ser  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      LOAD: begin
        a_ctrl = 2'b11;
        q_ctrl = 2'b11;
        busy   = 1'b1;
      end
      ADD: begin
        busy = 1'b1;
        if (q_lsb) begin
          a_ctrl = 2'b11;
          a_par  = sum[N-1:0];
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        a_ctrl = 2'b01;
        a_ser  = carry_q;
        q_ctrl = 2'b01;
        q_ser  = a_reg[0];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - self-checking bench for shift_add_mult_ctrl
// Behavioural A/Q shift registers around N=8 and N=4 instances; products checked against m*q.
module tb_shift_add_mult_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic       start8, a_ser8, q_ser8, busy8, done8;
  logic [7:0] mc8, mp8, a8, q8, a_par8, q_par8;
  logic [1:0] a_ctrl8, q_ctrl8;

  logic       start4, a_ser4, q_ser4, busy4, done4;
  logic [3:0] mc4, mp4, a4, q4, a_par4, q_par4;
  logic [1:0] a_ctrl4, q_ctrl4;

  shift_add_mult_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .multiplicand(mc8), .multiplier(mp8),
    .a_reg(a8), .q_lsb(q8[0]), .a_ctrl(a_ctrl8), .a_par(a_par8), .a_ser(a_ser8),
    .q_ctrl(q_ctrl8), .q_par(q_par8), .q_ser(q_ser8), .busy(busy8), .done(done8)
  );

  shift_add_mult_ctrl #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .multiplicand(mc4), .multiplier(mp4),
    .a_reg(a4), .q_lsb(q4[0]), .a_ctrl(a_ctrl4), .a_par(a_par4), .a_ser(a_ser4),
    .q_ctrl(q_ctrl4), .q_par(q_par4), .q_ser(q_ser4), .busy(busy4), .done(done4)
  );

  // External shift registers: 11 load, 01 shift right with serial-in at MSB, else hold.
  wire sr_rst = ~rst_n;
  always @(posedge clk or posedge sr_rst) begin
    if (sr_rst) begin
      a8 <= '0; q8 <= '0; a4 <= '0; q4 <= '0;
    end else begin
      case (a_ctrl8) 2'b11: a8 <= a_par8; 2'b01: a8 <= {a_ser8, a8[7:1]}; default: ; endcase
      case (q_ctrl8) 2'b11: q8 <= q_par8; 2'b01: q8 <= {q_ser8, q8[7:1]}; default: ; endcase
      case (a_ctrl4) 2'b11: a4 <= a_par4; 2'b01: a4 <= {a_ser4, a4[3:1]}; default: ; endcase
      case (q_ctrl4) 2'b11: q4 <= q_par4; 2'b01: q4 <= {q_ser4, q4[3:1]}; default: ; endcase
    end
  end

  // One multiply; lat is the edge count from the accepting edge to the first cycle with done high.
  task automatic run_op(input bit sel4, input logic [7:0] m, input logic [7:0] q,
                        output int lat, output int nbusy, output int nadd_load,
                        output logic [15:0] prod);
    lat = -1; nbusy = 0; nadd_load = 0; prod = '0;
    @(negedge clk);
    if (sel4) begin start4 = 1'b1; mc4 = m[3:0]; mp4 = q[3:0]; end
    else begin start8 = 1'b1; mc8 = m; mp8 = q; end
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0;
    mc8 = 8'($urandom); mp8 = 8'($urandom); mc4 = 4'($urandom); mp4 = 4'($urandom);
    if (sel4 ? busy4 : busy8) nbusy++;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (sel4 ? done4 : done8) begin
        lat  = k;
        prod = sel4 ? {8'h00, a4, q4} : {a8, q8};
        break;
      end
      if (sel4 ? busy4 : busy8) nbusy++;
      if (((sel4 ? a_ctrl4 : a_ctrl8) == 2'b11) && (k % 2 == 1)) nadd_load++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
    mc8 = 8'h3C; mp8 = 8'hC3; mc4 = 4'h9; mp4 = 4'h6;
    #1;
    checks++;
    if ({a_ctrl8, q_ctrl8, a_par8, q_par8, a_ser8, q_ser8, busy8, done8} !== 22'h0) begin
      failures++;
      $display("FAIL reset_outputs8 got=%0h exp=0",
               {a_ctrl8, q_ctrl8, a_par8, q_par8, a_ser8, q_ser8, busy8, done8});
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_ctrl4, q_ctrl4, a_par4, q_par4, a_ser4, q_ser4, busy4, done4} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs4 got=%0h exp=0",
               {a_ctrl4, q_ctrl4, a_par4, q_par4, a_ser4, q_ser4, busy4, done4});
    end
  endtask

  task automatic test_basic;
    int lat, nb, na; logic [15:0] p;
    run_op(1'b0, 8'd13, 8'd11, lat, nb, na, p);
    checks++; if (lat !== 17) begin failures++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    checks++; if (p !== 16'h008F) begin failures++; $display("FAIL basic_product got=%h exp=008f", p); end
    checks++; if (nb !== 17) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=17", nb); end
  endtask

  task automatic test_max;
    int lat, nb, na; logic [15:0] p;
    run_op(1'b0, 8'd255, 8'd255, lat, nb, na, p);
    checks++; if (p !== 16'hFE01) begin failures++; $display("FAIL max_product got=%h exp=fe01", p); end
    checks++; if (na !== 8) begin failures++; $display("FAIL max_add_loads got=%0d exp=8", na); end
  endtask

  task automatic test_zero;
    int lat, nb, na; logic [15:0] p;
    run_op(1'b0, 8'd0, 8'hA5, lat, nb, na, p);
    checks++; if (p !== 16'h0000) begin failures++; $display("FAIL zero_m_product got=%h exp=0000", p); end
    run_op(1'b0, 8'h5A, 8'd0, lat, nb, na, p);
    checks++; if (p !== 16'h0000) begin failures++; $display("FAIL zero_q_product got=%h exp=0000", p); end
    checks++; if (na !== 0) begin failures++; $display("FAIL zero_q_add_loads got=%0d exp=0", na); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  ma [3];
    logic [7:0]  qa [3];
    int          dcyc [$];
    logic [15:0] dprod [$];
    ma = '{8'd7, 8'd200, 8'd1};
    qa = '{8'd9, 8'd3, 8'd1};
    @(negedge clk); start8 = 1'b1; mc8 = ma[0]; mp8 = qa[0];
    @(posedge clk); #1;
    mc8 = ma[1]; mp8 = qa[1];
    for (int k = 1; k <= 56; k++) begin
      @(posedge clk); #1;
      if (done8) begin dcyc.push_back(k); dprod.push_back({a8, q8}); end
      if (k == 19) begin mc8 = ma[2]; mp8 = qa[2]; end
    end
    start8 = 1'b0;
    checks++;
    if (dcyc.size() != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", dcyc.size()); end
    for (int i = 0; i < 3 && i < dcyc.size(); i++) begin
      checks++;
      if (dcyc[i] != 17 + 19 * i) begin
        failures++; $display("FAIL b2b_done_cycle[%0d] got=%0d exp=%0d", i, dcyc[i], 17 + 19 * i);
      end
      checks++;
      if (dprod[i] !== 16'(ma[i]) * 16'(qa[i])) begin
        failures++; $display("FAIL b2b_product[%0d] got=%0d exp=%0d", i, dprod[i], 16'(ma[i]) * 16'(qa[i]));
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, nb, na, ndone; logic [15:0] p;
    @(negedge clk); start8 = 1'b1; mc8 = 8'd100; mp8 = 8'd100;
    @(posedge clk); #1; start8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin @(posedge clk); #1; end
    checks++;
    if (!(busy8 === 1'b1 && a_ctrl8 === 2'b01)) begin
      failures++; $display("FAIL mid_in_shift got busy=%b a_ctrl=%b exp busy=1 a_ctrl=01", busy8, a_ctrl8);
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({a_ctrl8, q_ctrl8, a_par8, q_par8, a_ser8, q_ser8, busy8, done8, a8, q8} !== 38'h0) begin
      failures++;
      $display("FAIL mid_async_reset got=%0h exp=0",
               {a_ctrl8, q_ctrl8, a_par8, q_par8, a_ser8, q_ser8, busy8, done8, a8, q8});
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin @(posedge clk); #1; if (done8) ndone++; end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", ndone); end
    run_op(1'b0, 8'd6, 8'd7, lat, nb, na, p);
    checks++; if (p !== 16'd42) begin failures++; $display("FAIL mid_restart_product got=%0d exp=42", p); end
  endtask

  task automatic test_random;
    int lat, nb, na; logic [15:0] p; logic [7:0] m, q;
    for (int i = 0; i < 20; i++) begin
      m = 8'($urandom); q = 8'($urandom);
      run_op(1'b0, m, q, lat, nb, na, p);
      checks++;
      if (p !== 16'(m) * 16'(q) || lat !== 17) begin
        failures++; $display("FAIL rand8 m=%0d q=%0d got=%0d lat=%0d exp=%0d lat=17", m, q, p, lat, 16'(m) * 16'(q));
      end
    end
    for (int i = 0; i < 10; i++) begin
      m = 8'($urandom_range(0, 15)); q = 8'($urandom_range(0, 15));
      run_op(1'b1, m, q, lat, nb, na, p);
      checks++;
      if (p !== 16'(m) * 16'(q) || lat !== 9) begin
        failures++; $display("FAIL rand4 m=%0d q=%0d got=%0d lat=%0d exp=%0d lat=9", m, q, p, lat, 16'(m) * 16'(q));
      end
    end
  endtask

  task automatic test_n4;
    int lat, nb, na; logic [15:0] p;
    run_op(1'b1, 8'd15, 8'd15, lat, nb, na, p);
    checks++; if (lat !== 9) begin failures++; $display("FAIL n4_latency got=%0d exp=9", lat); end
    checks++; if (p !== 16'h00E1) begin failures++; $display("FAIL n4_product got=%h exp=00e1", p); end
    checks++; if (nb !== 9) begin failures++; $display("FAIL n4_busy_cycles got=%0d exp=9", nb); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max;
    test_zero;
    test_back_to_back;
    test_reset_mid;
    test_n4;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
